// File: rtl/llr_pingpong_mem.sv
// rtl/llr_pingpong_mem.sv - double-buffered LLR frame memory with saturating sign-magnitude conversion
//
// Purpose: the loader fills one bank with LANES converted LLRs per beat while the
// decoder reads the other bank through two registered read ports. Banks are handed
// over with an EMPTY/FULL flag each, a write pointer and a read pointer.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_in_valid / o_in_ready     input beat handshake
//   i_in_data                   LANES sign-magnitude LLRs, lane j at [j*IW +: IW]
//   i_frame_beats               beats in the frame (0 = DEPTH/LANES), sampled on first beat
//   i_flush                     abandon the partially written frame
//   o_frm_valid / o_frm_beats   read bank holds a complete frame / its beat count
//   i_frm_done                  decoder releases the read bank
//   i_rd_addrN / o_rd_dataN     two independent 1-cycle registered read ports
module llr_pingpong_mem #(
   parameter int DEPTH = 1024,
   parameter int LANES = 8,
   parameter int IW    = 8,
   parameter int OW    = 7,
   parameter int AW    = $clog2(DEPTH),
   parameter int BW    = $clog2(DEPTH/LANES+1)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   input  logic [LANES*IW-1:0] i_in_data,
   input  logic [BW-1:0]       i_frame_beats,
   input  logic                i_flush,
   output logic                o_frm_valid,
   output logic [BW-1:0]       o_frm_beats,
   input  logic                i_frm_done,
   input  logic [AW-1:0]       i_rd_addr0,
   input  logic [AW-1:0]       i_rd_addr1,
   output logic [OW-1:0]       o_rd_data0,
   output logic [OW-1:0]       o_rd_data1
);

   localparam int NBEATS = DEPTH / LANES;
   localparam int SATMAX = (1 << (OW-1)) - 1;

   logic [OW-1:0] mem [2][DEPTH];

   logic [1:0]    full_q;
   logic          wr_bank_q;
   logic          rd_bank_q;
   logic          rst_done_q;
   logic [BW-1:0] wr_cnt_q;
   logic [BW-1:0] lat_beats_q;
   logic [BW-1:0] beats_q [2];

   logic          accept;
   logic          release_frm;
   logic          last_beat;
   logic [BW-1:0] frame_beats;
   logic [BW-1:0] cur_beats;
   logic [AW-1:0] wr_base;
   logic          rd_ok0;
   logic          rd_ok1;
   logic [OW-1:0] rd_mux0;
   logic [OW-1:0] rd_mux1;

   // Magnitude saturates to +/-SATMAX, so the most negative code never appears
   // and a negative zero negates to plain zero.
   function automatic logic [OW-1:0] to_twos(input logic [IW-1:0] llr);
      logic [31:0]   mag;
      logic [OW-1:0] sat;
      mag = 32'(llr[IW-2:0]);
      sat = (mag > SATMAX) ? OW'(SATMAX) : OW'(mag);
      return llr[IW-1] ? ((~sat) + OW'(1)) : sat;
   endfunction

   // rst_done_q keeps o_in_ready low while reset is held even though the flags read EMPTY.
   assign o_in_ready  = rst_done_q && !full_q[wr_bank_q] && !i_flush;
   assign accept      = i_in_valid && o_in_ready;
   assign o_frm_valid = full_q[rd_bank_q];
   assign o_frm_beats = beats_q[rd_bank_q];
   assign release_frm = i_frm_done && o_frm_valid;

   // The first beat of a frame uses the live length so a one-beat frame completes at once.
   assign frame_beats = (i_frame_beats == '0) ? BW'(NBEATS) : i_frame_beats;
   assign cur_beats   = (wr_cnt_q == '0) ? frame_beats : lat_beats_q;
   assign last_beat   = accept && (wr_cnt_q == cur_beats - 1'b1);
   assign wr_base     = AW'(32'(wr_cnt_q) * LANES);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rst_done_q  <= 1'b0;
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         lat_beats_q <= '0;
         beats_q[0]  <= '0;
         beats_q[1]  <= '0;
      end else begin
         rst_done_q <= 1'b1;
         if (i_flush) begin
            wr_cnt_q <= '0;
         end else if (accept) begin
            if (wr_cnt_q == '0) begin
               lat_beats_q <= frame_beats;
            end
            if (last_beat) begin
               full_q[wr_bank_q]  <= 1'b1;
               beats_q[wr_bank_q] <= cur_beats;
               wr_bank_q          <= ~wr_bank_q;
               wr_cnt_q           <= '0;
            end else begin
               wr_cnt_q <= wr_cnt_q + 1'b1;
            end
         end
         // Completion and release always target different banks, so both may land together.
         if (release_frm) begin
            full_q[rd_bank_q] <= 1'b0;
            rd_bank_q         <= ~rd_bank_q;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int j = 0; j < LANES; j++) begin
            mem[wr_bank_q][wr_base + AW'(j)] <= to_twos(i_in_data[j*IW +: IW]);
         end
      end
   end

   // Addresses beyond DEPTH can only occur when DEPTH is not a power of two.
   generate
      if (DEPTH == (1 << AW)) begin : g_full_range
         assign rd_ok0 = 1'b1;
         assign rd_ok1 = 1'b1;
      end else begin : g_part_range
         assign rd_ok0 = (32'(i_rd_addr0) < DEPTH);
         assign rd_ok1 = (32'(i_rd_addr1) < DEPTH);
      end
   endgenerate

   always_comb begin
      rd_mux0 = '0;
      rd_mux1 = '0;
      if (rd_ok0) rd_mux0 = mem[rd_bank_q][i_rd_addr0];
      if (rd_ok1) rd_mux1 = mem[rd_bank_q][i_rd_addr1];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rd_data0 <= '0;
         o_rd_data1 <= '0;
      end else begin
         o_rd_data0 <= rd_mux0;
         o_rd_data1 <= rd_mux1;
      end
   end

endmodule

// File: tb/tb_llr_pingpong_mem.sv
// tb/tb_llr_pingpong_mem.sv - directed self-checking bench for llr_pingpong_mem
module tb_llr_pingpong_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic [7:0]  frame_beats = '0;
   logic        flush = 1'b0;
   logic        frm_valid;
   logic [7:0]  frm_beats;
   logic        frm_done = 1'b0;
   logic [9:0]  rd_addr0 = '0;
   logic [9:0]  rd_addr1 = '0;
   logic [6:0]  rd_data0;
   logic [6:0]  rd_data1;

   int total = 0;
   int bad   = 0;
   int n;
   logic rdy;
   int e1[8] = '{5, -5, 0, 63, -63, 63, -63, 1};
   int pa0[4] = '{1023, 7, 520, 100};
   int pa1[4] = '{0, 1016, 3, 900};

   llr_pingpong_mem dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_data     (in_data),
      .i_frame_beats (frame_beats),
      .i_flush       (flush),
      .o_frm_valid   (frm_valid),
      .o_frm_beats   (frm_beats),
      .i_frm_done    (frm_done),
      .i_rd_addr0    (rd_addr0),
      .i_rd_addr1    (rd_addr1),
      .o_rd_data0    (rd_data0),
      .o_rd_data1    (rd_data1)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Lane j of beat k carries magnitude (k+j+off)%64 with a common sign.
   function automatic logic [63:0] mkbeat(input int k, input int sgn, input int off);
      logic [63:0] d;
      for (int j = 0; j < 8; j++) d[j*8 +: 8] = {sgn[0], 7'((k + j + off) % 64)};
      return d;
   endfunction

   function automatic int expv(input int x, input int sgn, input int off);
      int m;
      m = (x / 8 + x % 8 + off) % 64;
      return (sgn != 0) ? -m : m;
   endfunction

   task automatic rd(input string tag, input int a0, input int a1, input int ex0, input int ex1);
      rd_addr0 = 10'(a0);
      rd_addr1 = 10'(a1);
      step();
      chk({tag, "_p0"}, int'($signed(rd_data0)), ex0);
      chk({tag, "_p1"}, int'($signed(rd_data1)), ex1);
   endtask

   task automatic send(input int k, input int sgn, input int off);
      in_data = mkbeat(k, sgn, off);
      step();
   endtask

   initial begin
      // reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_fv", int'(frm_valid), 0);
      chk("rst_fb", int'(frm_beats), 0);
      chk("rst_rd0", int'(rd_data0), 0);
      chk("rst_rd1", int'(rd_data1), 0);
      repeat (2) step();
      chk("rst_hold_ready", int'(in_ready), 0);
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("post_rst_ready", int'(in_ready), 1);

      // single 2-beat frame with conversion corner cases
      in_valid = 1'b1;
      frame_beats = 8'd2;
      in_data = {8'h01, 8'hC0, 8'h3F, 8'hFF, 8'h7F, 8'h80, 8'h85, 8'h05};
      step();
      chk("f1_fv_early", int'(frm_valid), 0);
      step();
      in_valid = 1'b0;
      chk("f1_fv", int'(frm_valid), 1);
      chk("f1_fb", int'(frm_beats), 2);
      chk("f1_ready", int'(in_ready), 1);
      for (int i = 0; i < 8; i++) rd("f1_conv", i, i + 8, e1[i], e1[i]);
      frm_done = 1'b1;
      step();
      frm_done = 1'b0;
      chk("f1_released", int'(frm_valid), 0);

      // two back-to-back full frames: A (positive) into bank 1, B (negative) into bank 0
      frame_beats = 8'd0;
      in_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 256; c++) begin
         in_data = (n < 128) ? mkbeat(n, 0, 0) : mkbeat(n - 128, 1, 0);
         rdy = in_ready;
         step();
         if (rdy) n++;
      end
      chk("b2b_accepted", n, 256);
      chk("b2b_ready_low", int'(in_ready), 0);
      chk("b2b_fv", int'(frm_valid), 1);
      chk("b2b_fb", int'(frm_beats), 128);

      // third frame C stalls until A is released
      frame_beats = 8'd4;
      in_data = mkbeat(0, 0, 10);
      step();
      step();
      chk("c_stall", int'(in_ready), 0);
      for (int i = 0; i < 4; i++) rd("a_pipe", pa0[i], pa1[i], expv(pa0[i], 0, 0), expv(pa1[i], 0, 0));
      frm_done = 1'b1;
      step();
      frm_done = 1'b0;
      chk("c_resume", int'(in_ready), 1);
      step();
      send(1, 0, 10);
      send(2, 0, 10);
      send(3, 0, 10);
      in_valid = 1'b0;
      chk("b_fv", int'(frm_valid), 1);
      chk("b_fb", int'(frm_beats), 128);
      rd("b_data", 5, 1000, expv(5, 1, 0), expv(1000, 1, 0));
      frm_done = 1'b1;
      step();
      frm_done = 1'b0;
      chk("c_fb", int'(frm_beats), 4);
      rd("c_data", 0, 31, expv(0, 0, 10), expv(31, 0, 10));
      rd("c_data2", 12, 25, expv(12, 0, 10), expv(25, 0, 10));

      // flush after 3 of 4 beats of D, then a clean 4-beat frame E into bank 0
      in_valid = 1'b1;
      frame_beats = 8'd4;
      send(0, 1, 20);
      send(1, 1, 20);
      send(2, 1, 20);
      in_data = mkbeat(3, 1, 20);
      flush = 1'b1;
      #1;
      chk("flush_ready", int'(in_ready), 0);
      step();
      flush = 1'b0;
      send(0, 0, 30);
      send(1, 0, 30);
      send(2, 0, 30);
      chk("e_fv_early_ready", int'(in_ready), 1);
      send(3, 0, 30);
      in_valid = 1'b0;
      chk("e_both_full", int'(in_ready), 0);
      rd("c_untouched", 31, 7, expv(31, 0, 10), expv(7, 0, 10));
      frm_done = 1'b1;
      step();
      frm_done = 1'b0;
      chk("e_fv", int'(frm_valid), 1);
      chk("e_fb", int'(frm_beats), 4);
      rd("e_data", 0, 9, expv(0, 0, 30), expv(9, 0, 30));
      rd("e_data2", 31, 24, expv(31, 0, 30), expv(24, 0, 30));

      // 1-beat frame F completes in the same cycle E is released
      in_valid = 1'b1;
      frame_beats = 8'd1;
      in_data = mkbeat(0, 1, 40);
      frm_done = 1'b1;
      step();
      in_valid = 1'b0;
      frm_done = 1'b0;
      chk("same_fv", int'(frm_valid), 1);
      chk("same_ready", int'(in_ready), 1);
      chk("same_fb", int'(frm_beats), 1);
      rd("f_data", 3, 7, expv(3, 1, 40), expv(7, 1, 40));

      // reset asserted mid-frame and mid-read
      in_valid = 1'b1;
      frame_beats = 8'd4;
      send(0, 0, 50);
      send(1, 0, 50);
      chk("pre_rst_rd0", int'($signed(rd_data0)), expv(3, 1, 40));
      in_data = mkbeat(2, 0, 50);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", int'(in_ready), 0);
      chk("mid_rst_fv", int'(frm_valid), 0);
      chk("mid_rst_fb", int'(frm_beats), 0);
      chk("mid_rst_rd0", int'(rd_data0), 0);
      chk("mid_rst_rd1", int'(rd_data1), 0);
      in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("rel_ready", int'(in_ready), 1);
      chk("rel_fv", int'(frm_valid), 0);
      in_valid = 1'b1;
      frame_beats = 8'd2;
      send(0, 1, 5);
      send(1, 1, 5);
      in_valid = 1'b0;
      chk("h_fv", int'(frm_valid), 1);
      chk("h_fb", int'(frm_beats), 2);
      rd("h_data", 0, 15, expv(0, 1, 5), expv(15, 1, 5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
